// File: rtl/rids_stream_merger.sv
// Serial two-pointer RIDS merger: folds a valid/ready stream of ascending RIDS into one RIDS,
// by union (smallest NUM_RID distinct RIDs) or by intersection, selected on a group's first beat.
//
// state | meaning
// IDLE  | waiting for the first beat of a group; it becomes the accumulator
// WAIT  | waiting for the next operand beat of the group
// MERGE | walking accumulator and operand with two pointers, one result slot per cycle
// OUT   | presenting the merged result until the consumer takes it
module rids_stream_merger #(
    parameter int RID_WIDTH   = 4,
    parameter int NUM_RID     = 8,
    parameter int log_NUM_RID = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [RID_WIDTH*NUM_RID-1:0]   in_rids,
    input  logic                           in_last,
    input  logic                           mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RID_WIDTH*NUM_RID-1:0]   out_rids,
    output logic [log_NUM_RID:0]           out_count,
    output logic                           out_overflow
);
    localparam int CW = log_NUM_RID + 1;
    localparam logic [RID_WIDTH-1:0] SENT = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MERGE, S_OUT} state_t;

    state_t               state, state_nx;
    logic [RID_WIDTH-1:0] acc    [NUM_RID];
    logic [RID_WIDTH-1:0] opb    [NUM_RID];
    logic [RID_WIDTH-1:0] res    [NUM_RID];
    logic [RID_WIDTH-1:0] in_slot[NUM_RID];
    logic [CW-1:0]        pa, pb, k;
    logic                 mode_q, last_q, ovf;

    logic                 beat;
    logic [RID_WIDTH-1:0] a, b, pick;
    logic                 a_lt_b, b_lt_a, a_eq_b, take, done, ovf_set;
    logic [CW-1:0]        cnt;

    always_comb begin
        for (int i = 0; i < NUM_RID; i++)
            in_slot[i] = in_rids[(NUM_RID-1-i)*RID_WIDTH +: RID_WIDTH];
    end

    assign beat = in_valid && in_ready;

    // Pointer update is the same for both modes; only whether a slot is written differs.
    always_comb begin
        a       = (pa == CW'(NUM_RID)) ? SENT : acc[pa[log_NUM_RID-1:0]];
        b       = (pb == CW'(NUM_RID)) ? SENT : opb[pb[log_NUM_RID-1:0]];
        a_lt_b  = a < b;
        b_lt_a  = b < a;
        a_eq_b  = a == b;
        pick    = b_lt_a ? b : a;
        take    = mode_q ? a_eq_b : 1'b1;
        // Intersection can stop as soon as either side runs out; nothing further can match.
        done    = (k == CW'(NUM_RID)) || (a == SENT && b == SENT)
                  || (mode_q && (a == SENT || b == SENT));
        ovf_set = !mode_q && (k == CW'(NUM_RID)) && (pick != SENT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (beat) state_nx = in_last ? S_OUT : S_WAIT;
            S_WAIT:  if (beat) state_nx = S_MERGE;
            S_MERGE: if (done) state_nx = last_q ? S_OUT : S_WAIT;
            S_OUT:   if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '{default: SENT};
            opb    <= '{default: SENT};
            res    <= '{default: SENT};
            pa     <= '0;
            pb     <= '0;
            k      <= '0;
            mode_q <= 1'b0;
            last_q <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (beat) begin
                    acc    <= in_slot;
                    mode_q <= mode;
                    ovf    <= 1'b0;
                end
                S_WAIT: if (beat) begin
                    opb    <= in_slot;
                    last_q <= in_last;
                    pa     <= '0;
                    pb     <= '0;
                    k      <= '0;
                    res    <= '{default: SENT};
                end
                S_MERGE: begin
                    if (done) begin
                        acc <= res;
                        if (ovf_set) ovf <= 1'b1;
                    end else begin
                        if (take) res[k[log_NUM_RID-1:0]] <= pick;
                        k  <= k + CW'(take);
                        pa <= pa + CW'(a_eq_b || a_lt_b);
                        pb <= pb + CW'(a_eq_b || b_lt_a);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_RID; i++)
            if (acc[i] != SENT) cnt = cnt + CW'(1);
    end

    always_comb begin
        in_ready     = (state == S_IDLE) || (state == S_WAIT);
        out_valid    = (state == S_OUT);
        out_rids     = '1;
        out_count    = '0;
        out_overflow = 1'b0;
        if (state == S_OUT) begin
            for (int i = 0; i < NUM_RID; i++)
                out_rids[(NUM_RID-1-i)*RID_WIDTH +: RID_WIDTH] = acc[i];
            out_count    = cnt;
            out_overflow = ovf;
        end
    end
endmodule

// File: tb/tb_rids_stream_merger.sv
// Bench for rids_stream_merger at RID_WIDTH=4, NUM_RID=4: directed cases plus random groups
// checked against a set-based reference model (bitmask union/intersection).
module tb_rids_stream_merger;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int LG = 2;

    logic           clk = 1'b0, reset = 1'b0;
    logic           in_valid = 1'b0, in_last = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [W*N-1:0] in_rids = '1;
    logic           in_ready, out_valid, out_overflow;
    logic [W*N-1:0] out_rids;
    logic [LG:0]    out_count;
    int             total = 0, bad = 0;

    always #5 clk = ~clk;

    rids_stream_merger #(.RID_WIDTH(W), .NUM_RID(N), .log_NUM_RID(LG)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rids(in_rids), .in_last(in_last), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_rids(out_rids), .out_count(out_count),
        .out_overflow(out_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: a RIDS is a set, held as a 15-bit mask over the valid RID values.
    function automatic logic [14:0] to_mask(input logic [W*N-1:0] r);
        logic [14:0] m = '0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] v = r[(N-1-i)*W +: W];
            if (v != 4'hF) m[v] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [W*N-1:0] from_mask(input logic [14:0] m);
        logic [W*N-1:0] r = '1;
        int j = 0;
        for (int v = 0; v < 15; v++)
            if (m[v] && j < N) begin
                r[(N-1-j)*W +: W] = W'(v);
                j++;
            end
        return r;
    endfunction

    function automatic logic [14:0] keep_low(input logic [14:0] m, input int n);
        logic [14:0] o = '0;
        int c = 0;
        for (int v = 0; v < 15; v++)
            if (m[v] && c < n) begin
                o[v] = 1'b1;
                c++;
            end
        return o;
    endfunction

    function automatic logic [W*N-1:0] rand_beat();
        int          n  = $urandom_range(0, N);
        int          hi = ($urandom_range(0, 3) == 0) ? 14 : 7;
        logic [14:0] m  = '0;
        while ($countones(m) < n) m[$urandom_range(0, hi)] = 1'b1;
        return from_mask(m);
    endfunction

    task automatic model(input logic [W*N-1:0] bs[4], input int nb, input bit md,
                         output logic [W*N-1:0] r, output int c, output bit o);
        logic [14:0] acc = to_mask(bs[0]);
        o = 1'b0;
        for (int i = 1; i < nb; i++) begin
            logic [14:0] bm = to_mask(bs[i]);
            if (!md) begin
                logic [14:0] u = acc | bm;
                if ($countones(u) > N) o = 1'b1;
                acc = keep_low(u, N);
            end else begin
                acc = acc & bm;
            end
        end
        r = from_mask(acc);
        c = $countones(acc);
    endtask

    task automatic send_beat(input string tag, input logic [W*N-1:0] r, input bit l, input bit m);
        int n = 0;
        in_valid = 1'b1;
        in_rids  = r;
        in_last  = l;
        mode     = m;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk({tag, "_ready_timeout"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Later beats carry the opposite mode to show only the first beat's mode matters.
    task automatic send_group(input string tag, input logic [W*N-1:0] bs[4], input int nb, input bit md);
        for (int i = 0; i < nb; i++)
            send_beat(tag, bs[i], i == nb - 1, (i == 0) ? md : !md);
    endtask

    task automatic get_result(input string tag, input logic [W*N-1:0] er, input int ec,
                              input bit eo, input int max_wait);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < max_wait) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_rids"},  out_rids,  er);
        chk({tag, "_count"}, out_count, ec);
        chk({tag, "_ovf"},   out_overflow, eo);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        logic [W*N-1:0] bs[4];
        logic [W*N-1:0] er;
        int             ec;
        bit             eo, md;
        int             nb;

        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_rids",  out_rids,  16'hFFFF);
        chk("rst_count", out_count, 0);
        chk("rst_ovf",   out_overflow, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", in_ready, 1);

        bs = '{16'h1357, 16'h236F, 16'hFFFF, 16'hFFFF};
        send_group("t1", bs, 2, 1'b0);
        get_result("t1", 16'h1235, 4, 1'b1, 2 * N);

        bs = '{16'h1248, 16'h249F, 16'h04EF, 16'hFFFF};
        send_group("t2", bs, 3, 1'b1);
        get_result("t2", 16'h4FFF, 1, 1'b0, 2 * N);

        send_beat("t3", 16'h05AF, 1'b1, 1'b1);
        chk("t3_latency", out_valid, 1);
        get_result("t3", 16'h05AF, 3, 1'b0, 0);

        bs = '{16'hFFFF, 16'h12FF, 16'hFFFF, 16'hFFFF};
        send_group("t4u", bs, 2, 1'b0);
        get_result("t4u", 16'h12FF, 2, 1'b0, 2 * N);
        send_group("t4i", bs, 2, 1'b1);
        get_result("t4i", 16'hFFFF, 0, 1'b0, 2 * N);

        send_beat("t5", 16'h369F, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_rids  = 16'h0FFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_rids",  out_rids,  16'h369F);
            chk("t5_hold_count", out_count, 3);
            chk("t5_hold_ready", in_ready,  0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        get_result("t5", 16'h369F, 3, 1'b0, 0);
        chk("t5_back_idle", in_ready, 1);
        send_beat("t5n", 16'h7FFF, 1'b1, 1'b0);
        get_result("t5n", 16'h7FFF, 1, 1'b0, 0);

        send_beat("t6", 16'h1357, 1'b0, 1'b0);
        send_beat("t6", 16'h2468, 1'b1, 1'b0);
        chk("t6_merge_busy", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_rids",  out_rids,  16'hFFFF);
        chk("t6_rst_count", out_count, 0);
        chk("t6_rst_ovf",   out_overflow, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send_beat("t6n", 16'h1FFF, 1'b1, 1'b0);
        get_result("t6n", 16'h1FFF, 1, 1'b0, 0);

        for (int g = 0; g < 60; g++) begin
            md = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) bs[i] = rand_beat();
            model(bs, nb, md, er, ec, eo);
            send_group("rnd", bs, nb, md);
            get_result("rnd", er, ec, eo, 2 * N);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
